// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: buffers fetched {pc, instr} pairs in a FIFO
// so fetch can run ahead of a stalled decode; flushes on jump/JTAG reset.
module instr_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic bus_ready_i,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic jtag_reset_flag_i,
  input  logic halt_i,
  output logic valid_o,
  input  logic ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic full;
  logic push;
  logic pop;
  logic flush;

  assign full  = (level == LW'(DEPTH));
  assign flush = jtag_reset_flag_i | jump_flag_i;

  // Full blocks the request even when a pop frees a slot this cycle.
  assign bus_req_o = rst_ni & ~halt_i & ~flush & ~full;
  assign bus_addr_o = fetch_pc;

  assign push = bus_req_o & bus_ready_i;
  assign pop  = valid_o & ready_i;

  assign valid_o   = (level != '0);
  assign level_o   = level;
  assign instr_o   = valid_o ? instr_mem[rd_ptr] : '0;
  assign pc_o      = valid_o ? pc_mem[rd_ptr] : '0;
  assign pc_next_o = pc_o + ADDR_W'(PC_STEP);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (jtag_reset_flag_i) begin
      fetch_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (jump_flag_i) begin
      fetch_pc <= {jump_addr_i[ADDR_W-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10: level <= level + LW'(1);
        2'b01: level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Payload storage needs no reset; valid_o gates its visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr] <= fetch_pc;
      instr_mem[wr_ptr] <= bus_data_i;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: fill/drain, jump, JTAG reset,
// halt, PC wrap and mid-burst reset.
module tb_instr_prefetch;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic bus_req_o;
  logic [31:0] bus_addr_o;
  logic bus_ready_i;
  logic [31:0] bus_data_i;
  logic jump_flag_i;
  logic [31:0] jump_addr_i;
  logic jtag_reset_flag_i;
  logic halt_i;
  logic valid_o;
  logic ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_next_o;
  logic [2:0] level_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Memory model: instruction word is derived from its address.
  assign bus_data_i = bus_addr_o ^ 32'hA5A5_0000;

  instr_prefetch #(
    .DEPTH(4), .ADDR_W(32), .DATA_W(32),
    .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus_req_o(bus_req_o),
    .bus_addr_o(bus_addr_o),
    .bus_ready_i(bus_ready_i),
    .bus_data_i(bus_data_i),
    .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i),
    .jtag_reset_flag_i(jtag_reset_flag_i),
    .halt_i(halt_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .pc_next_o(pc_next_o),
    .level_o(level_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    bus_ready_i = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    jtag_reset_flag_i = 1'b0;
    halt_i = 1'b0;
    ready_i = 1'b0;
    step();
    step();
    chk("rst_valid", valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);

    // Streaming: one instruction per cycle, level stays 1
    rst_ni = 1'b1;
    bus_ready_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("str_req", bus_req_o, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("str_pc", pc_o, 4 * i);
      chk("str_instr", instr_o, (4 * i) ^ 32'hA5A5_0000);
      chk("str_level", level_o, 1);
    end

    // JTAG reset flushes and returns to RESET_PC
    jtag_reset_flag_i = 1'b1;
    #1;
    chk("jtag_req", bus_req_o, 0);
    step();
    jtag_reset_flag_i = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("jtag_level", level_o, 0);
    chk("jtag_addr", bus_addr_o, 0);

    // Fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_level", level_o, i + 1);
    end
    chk("full_req", bus_req_o, 0);
    chk("full_addr", bus_addr_o, 32'h10);
    chk("full_pc", pc_o, 0);
    step();
    chk("full_hold_lvl", level_o, 4);
    chk("full_hold_req", bus_req_o, 0);
    ready_i = 1'b1;
    #1;
    chk("full_pop_req", bus_req_o, 0);
    chk("drain_pc0", pc_o, 0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("drain_pc", pc_o, 4 * j);
      chk("drain_level", level_o, 3);
      if (j == 1) begin
        chk("resume_req", bus_req_o, 1);
        chk("resume_addr", bus_addr_o, 32'h10);
      end
    end

    // Jump with 3 entries buffered
    ready_i = 1'b0;
    bus_ready_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h8000_0102;
    #1;
    chk("jmp_req", bus_req_o, 0);
    step();
    jump_flag_i = 1'b0;
    #1;
    chk("jmp_valid", valid_o, 0);
    chk("jmp_level", level_o, 0);
    chk("jmp_addr", bus_addr_o, 32'h8000_0100);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    chk("jmp_pc", pc_o, 32'h8000_0100);
    chk("jmp_instr", instr_o, 32'h8000_0100 ^ 32'hA5A5_0000);

    // Jump and JTAG reset together: JTAG wins
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_1234;
    jtag_reset_flag_i = 1'b1;
    step();
    jump_flag_i = 1'b0;
    jtag_reset_flag_i = 1'b0;
    #1;
    chk("both_addr", bus_addr_o, 0);
    chk("both_level", level_o, 0);
    chk("both_valid", valid_o, 0);

    // Halt drains the FIFO without new requests
    bus_ready_i = 1'b1;
    step();
    step();
    chk("halt_pre_lvl", level_o, 2);
    halt_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("halt_req0", bus_req_o, 0);
    step();
    chk("halt_lvl1", level_o, 1);
    chk("halt_pc1", pc_o, 4);
    chk("halt_req1", bus_req_o, 0);
    chk("halt_addr1", bus_addr_o, 8);
    step();
    chk("halt_lvl0", level_o, 0);
    chk("halt_req2", bus_req_o, 0);
    chk("halt_addr2", bus_addr_o, 8);
    halt_i = 1'b0;
    #1;
    chk("unhalt_req", bus_req_o, 1);
    step();
    chk("unhalt_pc", pc_o, 8);
    chk("unhalt_valid", valid_o, 1);

    // PC wrap at the top of the address space
    bus_ready_i = 1'b0;
    ready_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFF;
    step();
    jump_flag_i = 1'b0;
    bus_ready_i = 1'b1;
    #1;
    chk("wrap_addr0", bus_addr_o, 32'hFFFF_FFFC);
    step();
    bus_ready_i = 1'b0;
    #1;
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next_o, 0);
    chk("wrap_addr1", bus_addr_o, 0);

    // Reset mid-burst with 3 entries buffered
    bus_ready_i = 1'b1;
    step();
    step();
    chk("mid_lvl", level_o, 3);
    rst_ni = 1'b0;
    step();
    chk("mid_valid", valid_o, 0);
    chk("mid_level", level_o, 0);
    chk("mid_addr", bus_addr_o, 0);
    chk("mid_req", bus_req_o, 0);
    rst_ni = 1'b1;
    bus_ready_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Parametrised successor to the single-entry instruction fetch stage of the tinyriscv core.
- Keeps a configurable-depth FIFO of fetched {pc, instruction} pairs between the instruction bus (rib pc port) and if_id, so fetch runs ahead of a stalled decode.
- Flushes on jump or JTAG PC reset.
- Stops issuing bus requests on halt without losing already-buffered instructions.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- ADDR_W, 32, PC/bus address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0, fetch address after reset and after JTAG reset.
- PC_STEP, 4, bytes added to the PC per fetched instruction.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- bus_req_o  out  1  fetch request to instruction bus.
- bus_addr_o  out  ADDR_W  fetch address.
- bus_ready_i  in  1  bus accepts request; bus_data_i valid in the same cycle.
- bus_data_i  in  DATA_W  fetched instruction.
- jump_flag_i  in  1  redirect from ctrl.
- jump_addr_i  in  ADDR_W  redirect target.
- jtag_reset_flag_i  in  1  JTAG PC reset.
- halt_i  in  1  stop issuing new requests (jtag halt / ctrl hold).
- valid_o  out  1  head entry valid to if_id.
- ready_i  in  1  if_id accepts head entry.
- instr_o  out  DATA_W  head instruction.
- pc_o  out  ADDR_W  head instruction address.
- pc_next_o  out  ADDR_W  pc_o + PC_STEP (modulo 2^ADDR_W).
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_ni=0 sampled at posedge):
  - fetch_pc=RESET_PC; FIFO empty; read and write pointers 0.
  - Outputs after reset: valid_o=0, level_o=0, bus_req_o=0 during reset cycle, bus_addr_o=RESET_PC.
  - instr_o and pc_o are don't-care while valid_o=0; the implementation drives 0.
- Priority per cycle: reset > jtag_reset_flag_i > jump_flag_i > normal operation.
- bus_req_o is combinational: bus_req_o = rst_ni & ~halt_i & ~jtag_reset_flag_i & ~jump_flag_i & (level < DEPTH).
  - Full FIFO: no request, even if a pop happens in the same cycle. This is deliberate, to keep the ready path short.
- bus_addr_o = fetch_pc.
- Push: bus_req_o & bus_ready_i.
  - Write {fetch_pc, bus_data_i} at the write pointer.
  - fetch_pc += PC_STEP.
  - Entry becomes visible on valid_o the next cycle (1-cycle latency, registered FIFO).
- Pop: valid_o & ready_i.
  - Advance the read pointer.
  - A simultaneous push and pop leaves level unchanged.
- valid_o = (level != 0) and holds until popped. instr_o and pc_o are stable while valid_o=1 and ready_i=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is a separate counter, 0..DEPTH inclusive.
- jump_flag_i=1:
  - Next cycle: FIFO empty, level=0, valid_o=0.
  - fetch_pc = {jump_addr_i[ADDR_W-1:2], 2'b00}.
  - Any bus response in that cycle is dropped (bus_req_o is already 0).
  - A pop in the same cycle is still reported to if_id as accepted; flushing is the consumer's concern.
- jtag_reset_flag_i=1: same as a jump with target RESET_PC.
- halt_i=1: no new requests. The FIFO still drains via ready_i and level decreases. fetch_pc is held.
- Jump during halt: fetch_pc is redirected and the FIFO flushed; fetching resumes at the new pc when halt_i drops.
- fetch_pc wraps modulo 2^ADDR_W.
- No x-propagation from bus_data_i into control logic.

Test Plan:
- Reset, then bus_ready_i=1 constantly, ready_i=1 → pc_o sequence 0x0,0x4,0x8,… from cycle 2; one instruction per cycle; level_o stays 1.
- ready_i=0, bus_ready_i=1, DEPTH=4 → exactly 4 pushes (addrs 0x0–0xC); bus_req_o=0 from the 5th cycle; level_o=4. Then raise ready_i → pops in order 0x0,0x4,0x8,0xC; req resumes at 0x10.
- Jump to 0x8000_0102 with 3 entries buffered → next cycle valid_o=0, level_o=0, bus_addr_o=0x8000_0100; first output pc_o=0x8000_0100.
- jump_flag_i and jtag_reset_flag_i together (RESET_PC=0x0) → bus_addr_o=0x0 next cycle; FIFO empty.
- halt_i=1 with 2 buffered entries, ready_i=1 → both drain; bus_req_o=0 throughout; bus_addr_o held. Release halt → fetching continues from the held address.
- Start at fetch_pc=0xFFFF_FFFC via jump, one fetch → pc_o=0xFFFF_FFFC, pc_next_o=0x0; next bus_addr_o=0x0.
- rst_ni=0 mid-burst with 3 entries buffered → next cycle valid_o=0, level_o=0, bus_addr_o=RESET_PC.
